// File: rtl/door_lock_pkg.sv
// Shared types and helpers for the keypad door-lock controller.
package door_lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INPUT   = 3'd1,
        CHECK   = 3'd2,
        UNLOCK  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // Width of the shared phase timer: it is always loaded with (cycles - 1),
    // so the largest phase length minus one must fit.
    function automatic int timer_w(input int unlock_c, input int lockout_c, input int timeout_c);
        int m;
        m = unlock_c;
        if (lockout_c > m) m = lockout_c;
        if (timeout_c > m) m = timeout_c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/door_lock_timer.sv
// Loadable down-counter with a zero flag, shared by the entry-timeout,
// unlock-hold and lockout phases of the door-lock controller.
module door_lock_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Reload on phase entry, otherwise count down and rest at zero
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/door_lock_ctrl.sv
// Keypad door-lock controller: collects a PASS_LEN-digit code over a
// valid/ready interface, compares it with the password, then holds the strike
// open for a timed window or counts the failure (timed lockout after
// MAX_TRIES consecutive failures). Stalled entries are discarded on timeout.
// Optional feature macro: LOCK_PROG_EN adds prog_valid/prog_pass so the
// password can be reprogrammed while unlocked.
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int                          DIGIT_W        = 4,
    parameter int                          PASS_LEN       = 4,
    parameter logic [DIGIT_W*PASS_LEN-1:0] PASSWORD       = 16'h1234,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          UNLOCK_CYCLES  = 8,
    parameter int                          LOCKOUT_CYCLES = 32,
    parameter int                          TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               digit_valid,
    input  logic [DIGIT_W-1:0]                 digit,
    output logic                               digit_ready,
    input  logic                               clear,
    output logic                               unlock,
    output logic                               error,
    output logic                               locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
`ifdef LOCK_PROG_EN
    ,
    input  logic                               prog_valid,
    input  logic [DIGIT_W*PASS_LEN-1:0]        prog_pass
`endif
);

    localparam int PW = DIGIT_W * PASS_LEN;
    localparam int CW = $clog2(PASS_LEN + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);

    // Saturating increment of the consecutive-failure count
    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
        if (v >= FW'(MAX_TRIES)) begin
            return v;
        end
        return v + FW'(1);
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_buf;
    logic [PW-1:0] w_buf_nxt;
    logic [PW-1:0] w_buf_shift;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [FW-1:0] r_fail;
    logic [FW-1:0] w_fail_nxt;
    logic [FW-1:0] w_fail_inc;
    logic          r_error;
    logic          w_error_nxt;
    logic          w_ready;
    logic          w_accept;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_zero;
    logic [PW-1:0] w_pass;

    // Digits are only taken while collecting a code; clear always blocks them
    assign w_ready    = ((r_state == IDLE) || (r_state == INPUT)) && !clear;
    assign w_accept   = w_ready && digit_valid;
    assign w_fail_inc = sat_inc(r_fail);

    // The first digit entered ends up in the most significant digit slot
    generate
        if (PASS_LEN > 1) begin : g_shift
            assign w_buf_shift = {r_buf[PW-DIGIT_W-1:0], digit};
        end else begin : g_single
            assign w_buf_shift = digit;
        end
    endgenerate

`ifdef LOCK_PROG_EN
    logic [PW-1:0] r_pass;

    // New password is taken only while the door is unlocked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pass <= PASSWORD;
        end else if ((r_state == UNLOCK) && prog_valid) begin
            r_pass <= prog_pass;
        end
    end

    assign w_pass = r_pass;
`else
    assign w_pass = PASSWORD;
`endif

    door_lock_timer #(
        .W(TW)
    ) u_timer (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // State, entry buffer, digit count, failure count and error pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_fail  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fail  <= w_fail_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Next-state, datapath updates and timer loads on each phase entry
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_fail_nxt  = r_fail;
        w_error_nxt = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = CW'(1);
                    if (PASS_LEN == 1) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = INPUT;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(TIMEOUT_CYCLES - 1);
                    end
                end
            end

            INPUT: begin
                if (clear) begin
                    w_state_nxt = IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_accept) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(PASS_LEN - 1)) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                    end
                end else if (w_tmr_zero) begin
                    // Stalled entry: drop it silently, failures untouched
                    w_state_nxt = IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end

            CHECK: begin
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
                if (r_buf == w_pass) begin
                    w_state_nxt = UNLOCK;
                    w_fail_nxt  = '0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(UNLOCK_CYCLES - 1);
                end else begin
                    w_error_nxt = 1'b1;
                    w_fail_nxt  = w_fail_inc;
                    if (w_fail_inc == FW'(MAX_TRIES)) begin
                        w_state_nxt = LOCKOUT;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            UNLOCK: begin
                if (clear || w_tmr_zero) begin
                    w_state_nxt = IDLE;
                end
            end

            LOCKOUT: begin
                // clear is deliberately ignored so a lockout cannot be cut short
                if (w_tmr_zero) begin
                    w_state_nxt = IDLE;
                    w_fail_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign digit_ready = w_ready;
    assign unlock      = (r_state == UNLOCK);
    assign locked_out  = (r_state == LOCKOUT);
    assign error       = r_error;
    assign fail_count  = r_fail;

endmodule
